r2r_wave_gen: RTL
=================

# r2r_wave_gen

Parametrised successor to the 8-bit R2R DAC controller: generates a digital sample stream for an R2R ladder of configurable width, with a programmable sample-rate divider, selectable waveform (ramp, triangle, square, hold) and an external-data bypass. It sits between the pad inputs and the per-bit level shifters (`dac_drive`) in the 1v8 domain. All pad-sourced control inputs are synchronised internally.

## Interface
Parameters:
- `WIDTH`, 8: DAC resolution in bits, legal range 2..12.
- `DIV_WIDTH`, 16: width of the clock-divider reload value.
- `DIV_RESET`, 0: divider reload value after reset.

Ports:
- `clk` in 1: single clock, nominally 10 MHz.
- `n_rst` in 1: reset, asynchronous and active-low.
- `ext_data` in 1: pad-level; high selects `data` as the DAC value.
- `load_divider` in 1: pad-level; a rising edge loads `div_in` into the divider.
- `mode` in 2: waveform select, pad-level.
- `data` in `WIDTH`: external sample value.
- `div_in` in `DIV_WIDTH`: divider reload value.
- `r2r_out` out `WIDTH`: registered code to the ladder drivers.
- `cnt_zero` out 1: one-cycle pulse per sample tick.
- `wrap` out 1: one-cycle pulse when the waveform completes a period.

## Operation
- Synchronisers: `ext_data`, `load_divider` and `mode` each pass through 2 flops, reset to 0. `load_divider` is edge-detected after synchronisation.
- Divider:
  - `div_reg` holds the reload value; `cnt` counts down from `div_reg` to 0, then reloads.
  - A tick occurs in the cycle where `cnt == 0`, giving a period of `div_reg+1` cycles. `div_reg = 0` produces a tick every cycle.
- Load: on a synchronised rising edge, `div_reg <= div_in` and `cnt <= div_in`. The tick due in that same cycle is suppressed.
- Modes (values from the shared package), waveform generated from `phase` (`WIDTH` bits) and `dir` (UP/DOWN):
  - RAMP=0: out = `phase`; `phase` increments per tick and wraps from max (2^WIDTH-1) to 0. `wrap` pulses on that tick.
  - TRI=1: `phase` steps ±1 per tick. `dir` flips to DOWN on reaching max and to UP on reaching 0. Endpoints are not repeated: 0,1,…,max,max-1,…,1,0,1. `wrap` pulses on the tick that reaches 0.
  - SQUARE=2: `phase` ramps as in RAMP; out = all bits equal to `phase[WIDTH-1]`. `wrap` as in RAMP.
  - HOLD=3: `phase` and out are frozen; ticks and `cnt_zero` continue; `wrap` stays 0.
- Mode change: when the synchronised `mode` differs from its previous value, `phase <= 0` and `dir <= UP` in that cycle, taking priority over any tick.
- External: while synchronised `ext_data` = 1, `r2r_out <= data` every cycle regardless of ticks. `phase` and `dir` are frozen; `cnt_zero` still pulses; `wrap` = 0. On deassertion, the waveform resumes from the frozen `phase` at the next tick.

## Timing
- Reset values: `r2r_out`=0, `cnt_zero`=0, `wrap`=0, `phase`=0, `dir`=UP, `div_reg`=`cnt`=`DIV_RESET`, all sync flops 0.
- `cnt_zero`, `wrap` and the new `r2r_out` value update on the same clock edge, one cycle after `cnt == 0`. All outputs are registered.
- Pad-to-effect latencies:
  - `ext_data` rise: `r2r_out` equals `data` after the 3rd rising edge.
  - `load_divider` rise: the load occurs at the 3rd edge.
  - `mode` change: `phase` resets at the 3rd edge.
- Reset asserted mid-period: all state returns to its reset value immediately and asynchronously. After release, the first tick occurs `DIV_RESET+1` cycles later.

## Structure
- Shared package `r2r_pkg`:
  - mode encoding constants `MODE_RAMP`, `MODE_TRI`, `MODE_SQUARE`, `MODE_HOLD`;
  - direction constants `DIR_UP`, `DIR_DOWN`;
  - default `WIDTH` and `DIV_WIDTH`.
- One sub-module `r2r_tick_div`: the divider with load, suppression and the `tick` output.
- The synchronisers and waveform logic stay in the top module.

## Test plan
All scenarios use `WIDTH`=8.

- Reset, then `div_in`=3 loaded, mode RAMP → `cnt_zero` every 4 cycles; `r2r_out` steps 0,1,2,…,255,0; `wrap` pulses once on the 255→0 tick.
- Mode TRI, `div_reg`=0 → `r2r_out` sequence 0..255..0 with no repeated 255 or 0; `wrap` on each return to 0; 510 ticks per period.
- Mode SQUARE, `div_reg`=0 → `r2r_out` is 0x00 for 128 ticks, then 0xFF for 128 ticks.
- `ext_data`=1 with `data`=0xA5 mid-ramp at `phase`=40 → `r2r_out`=0xA5 from the 3rd edge. After release, the next tick outputs 41.
- `load_divider` edge coinciding with `cnt==0` → no `cnt_zero` that cycle; the next pulse arrives `div_in`+1 cycles later.
- Mode changed from RAMP to TRI at `phase`=200; `n_rst` pulsed low mid-period → `phase` restarts at 0 with `dir`=UP; the reset pulse clears all outputs to 0 asynchronously.

Source files
------------

// File: rtl/r2r_pkg.sv
// Shared encodings and default sizes for the R2R ladder waveform generator.
package r2r_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        MODE_RAMP   = 2'd0,
        MODE_TRI    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/r2r_tick_div.sv
// Programmable sample-rate divider: counts down from the reload value and
// emits one tick per period; a load restarts the count and drops that cycle's tick.
module r2r_tick_div
    import r2r_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
    parameter int DIV_RESET = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div_in,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] RELOAD_RST = DIV_WIDTH'(DIV_RESET);
    localparam logic [DIV_WIDTH-1:0] CNT_ONE    = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] div_reg_q, div_reg_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        div_reg_d = div_reg_q;
        cnt_d     = cnt_q - CNT_ONE;
        tick      = 1'b0;
        if (load) begin
            div_reg_d = div_in;
            cnt_d     = div_in;
        end else if (cnt_q == '0) begin
            cnt_d = div_reg_q;
            tick  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            div_reg_q <= RELOAD_RST;
            cnt_q     <= RELOAD_RST;
        end else begin
            div_reg_q <= div_reg_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/r2r_wave_gen.sv
// R2R ladder sample generator: pad synchronisers, divider, and ramp/triangle/
// square/hold waveform engine with an external-data bypass. All outputs registered.
module r2r_wave_gen
    import r2r_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
    parameter int DIV_RESET = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 ext_data,
    input  logic                 load_divider,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     data,
    input  logic [DIV_WIDTH-1:0] div_in,
    output logic [WIDTH-1:0]     r2r_out,
    output logic                 cnt_zero,
    output logic                 wrap
);

    localparam logic [WIDTH-1:0] PHASE_MAX = '1;
    localparam logic [WIDTH-1:0] PHASE_ONE = WIDTH'(1);

    logic       ext_s1_q, ext_s2_q;
    logic       ld_s1_q, ld_s2_q, ld_prev_q;
    logic [1:0] mode_s1_q, mode_s2_q, mode_prev_q;

    logic [WIDTH-1:0] phase_q, phase_d;
    dir_e             dir_q, dir_d;
    logic [WIDTH-1:0] r2r_out_q, r2r_out_d;
    logic             cnt_zero_q, cnt_zero_d;
    logic             wrap_q, wrap_d;

    logic load_pulse;
    logic mode_change;
    logic tick;

    assign load_pulse  = ld_s2_q & ~ld_prev_q;
    assign mode_change = (mode_s2_q != mode_prev_q);

    r2r_tick_div #(
        .DIV_WIDTH(DIV_WIDTH),
        .DIV_RESET(DIV_RESET)
    ) u_tick_div (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (load_pulse),
        .div_in(div_in),
        .tick  (tick)
    );

    always_comb begin
        phase_d    = phase_q;
        dir_d      = dir_q;
        r2r_out_d  = r2r_out_q;
        wrap_d     = 1'b0;
        cnt_zero_d = tick;

        if (ext_s2_q) begin
            r2r_out_d = data;
        end

        // A mode change restarts the waveform and swallows any coincident tick.
        if (mode_change) begin
            phase_d = '0;
            dir_d   = DIR_UP;
        end else if (tick && !ext_s2_q) begin
            unique case (mode_s2_q)
                MODE_RAMP: begin
                    phase_d   = phase_q + PHASE_ONE;
                    wrap_d    = (phase_q == PHASE_MAX);
                    r2r_out_d = phase_d;
                end
                MODE_SQUARE: begin
                    phase_d   = phase_q + PHASE_ONE;
                    wrap_d    = (phase_q == PHASE_MAX);
                    r2r_out_d = {WIDTH{phase_d[WIDTH-1]}};
                end
                MODE_TRI: begin
                    // Direction flips on arrival at an endpoint so neither end repeats.
                    if (dir_q == DIR_UP) begin
                        phase_d = phase_q + PHASE_ONE;
                        if (phase_d == PHASE_MAX) begin
                            dir_d = DIR_DOWN;
                        end
                    end else begin
                        phase_d = phase_q - PHASE_ONE;
                        if (phase_d == '0) begin
                            dir_d  = DIR_UP;
                            wrap_d = 1'b1;
                        end
                    end
                    r2r_out_d = phase_d;
                end
                default: begin
                    // Hold: phase and output stay frozen while ticks keep running.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ext_s1_q    <= 1'b0;
            ext_s2_q    <= 1'b0;
            ld_s1_q     <= 1'b0;
            ld_s2_q     <= 1'b0;
            ld_prev_q   <= 1'b0;
            mode_s1_q   <= 2'b00;
            mode_s2_q   <= 2'b00;
            mode_prev_q <= 2'b00;
            phase_q     <= '0;
            dir_q       <= DIR_UP;
            r2r_out_q   <= '0;
            cnt_zero_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            ext_s1_q    <= ext_data;
            ext_s2_q    <= ext_s1_q;
            ld_s1_q     <= load_divider;
            ld_s2_q     <= ld_s1_q;
            ld_prev_q   <= ld_s2_q;
            mode_s1_q   <= mode;
            mode_s2_q   <= mode_s1_q;
            mode_prev_q <= mode_s2_q;
            phase_q     <= phase_d;
            dir_q       <= dir_d;
            r2r_out_q   <= r2r_out_d;
            cnt_zero_q  <= cnt_zero_d;
            wrap_q      <= wrap_d;
        end
    end

    assign r2r_out  = r2r_out_q;
    assign cnt_zero = cnt_zero_q;
    assign wrap     = wrap_q;

endmodule
